ex_operand_stage: RTL and testbench

ID/EX pipeline stage of the RV64 core: registers one decoded instruction per cycle and presents ready-to-use operands and operation select to the execute-stage ALU. It selects A (rs1 or PC) and B (rs2 or immediate), and forwards results from EX/MEM and MEM/WB. While a stalled entry is held, it also refreshes its stored register operands from MEM/WB writebacks. It uses a valid/ready handshake on both sides and supports flush for branch redirects.

---
 rtl/ex_operand_stage.sv | 119 +++++++++++
 tb/tb_ex_operand_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX register: holds one decoded instruction, muxes and forwards ALU operands.
// Latency: one cycle from capture to out_valid; forwarding into alu_a/alu_b/store data is combinational.
// Backpressure: single entry; in_ready = !valid | out_ready | flush, so drain and capture can share an edge.
module ex_operand_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_data,
    input  logic [DATA_WIDTH-1:0] in_rs2_data,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [4:0]            in_alu_sel,
    input  logic                  in_a_sel,
    input  logic                  in_b_sel,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0] exmem_data,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0] memwb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [4:0]            alu_sel,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rs1;
        logic [DATA_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] imm;
        logic [REG_ADDR_W-1:0] rs1a;
        logic [REG_ADDR_W-1:0] rs2a;
        logic [REG_ADDR_W-1:0] rd;
        logic [4:0]            sel;
        logic                  a_sel;
        logic                  b_sel;
        logic                  wr;
    } entry_t;

    entry_t entry_q;
    logic   valid_q;
    logic   capture;

    logic [DATA_WIDTH-1:0] fwd1;
    logic [DATA_WIDTH-1:0] fwd2;
    logic                  exmem_hit1, exmem_hit2, memwb_hit1, memwb_hit2;

    assign in_ready = !valid_q | out_ready | flush;
    assign capture  = in_valid & in_ready & !flush;

    // x0 is hardwired zero, so a producer targeting it must never be forwarded
    assign exmem_hit1 = exmem_reg_write && (exmem_rd == entry_q.rs1a) && (entry_q.rs1a != '0);
    assign exmem_hit2 = exmem_reg_write && (exmem_rd == entry_q.rs2a) && (entry_q.rs2a != '0);
    assign memwb_hit1 = memwb_reg_write && (memwb_rd == entry_q.rs1a) && (entry_q.rs1a != '0);
    assign memwb_hit2 = memwb_reg_write && (memwb_rd == entry_q.rs2a) && (entry_q.rs2a != '0);

    always_comb begin
        fwd1 = entry_q.rs1;
        if (exmem_hit1)      fwd1 = exmem_data;
        else if (memwb_hit1) fwd1 = memwb_data;
        fwd2 = entry_q.rs2;
        if (exmem_hit2)      fwd2 = exmem_data;
        else if (memwb_hit2) fwd2 = memwb_data;
    end

    assign alu_a          = entry_q.a_sel ? entry_q.pc  : fwd1;
    assign alu_b          = entry_q.b_sel ? entry_q.imm : fwd2;
    assign out_store_data = fwd2;
    assign alu_sel        = entry_q.sel;
    assign out_pc         = entry_q.pc;
    assign out_rd         = entry_q.rd;
    assign out_reg_write  = entry_q.wr;
    assign out_valid      = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            if (flush)          valid_q <= 1'b0;
            else if (capture)   valid_q <= 1'b1;
            else if (out_ready) valid_q <= 1'b0;

            if (capture) begin
                entry_q.pc    <= in_pc;
                entry_q.rs1   <= in_rs1_data;
                entry_q.rs2   <= in_rs2_data;
                entry_q.imm   <= in_imm;
                entry_q.rs1a  <= in_rs1_addr;
                entry_q.rs2a  <= in_rs2_addr;
                entry_q.rd    <= in_rd_addr;
                entry_q.sel   <= in_alu_sel;
                entry_q.a_sel <= in_a_sel;
                entry_q.b_sel <= in_b_sel;
                entry_q.wr    <= in_reg_write;
            end else if (valid_q) begin
                // a stalled entry must keep a writeback value after its producer retires
                if (memwb_hit1) entry_q.rs1 <= memwb_data;
                if (memwb_hit2) entry_q.rs2 <= memwb_data;
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [4:0]  in_alu_sel;
    logic        in_a_sel, in_b_sel, in_reg_write, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [63:0] exmem_data, memwb_data;
    logic        out_valid, out_ready;
    logic [63:0] alu_a, alu_b, out_store_data, out_pc;
    logic [4:0]  alu_sel, out_rd;
    logic        out_reg_write;

    int n_cmp = 0;
    int n_err = 0;

    ex_operand_stage #(.DATA_WIDTH(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_sel(in_alu_sel), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_reg_write(in_reg_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_data(exmem_data), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .out_store_data(out_store_data), .out_pc(out_pc),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [4:0] r1a, input logic [63:0] r1d,
                         input logic [4:0] r2a, input logic [63:0] r2d, input logic [63:0] imm,
                         input logic [4:0] sel, input logic asel, input logic bsel,
                         input logic [4:0] rd, input logic wr);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1_addr  = r1a;
        in_rs1_data  = r1d;
        in_rs2_addr  = r2a;
        in_rs2_data  = r2d;
        in_imm       = imm;
        in_alu_sel   = sel;
        in_a_sel     = asel;
        in_b_sel     = bsel;
        in_rd_addr   = rd;
        in_reg_write = wr;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_alu_sel = 0;
        in_a_sel = 0; in_b_sel = 0; in_reg_write = 0; flush = 0;
        exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_data = 0; memwb_data = 0; out_ready = 0;

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_store", out_store_data, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // single ADD: rs1=x5(7), rs2=x6(3)
        out_ready = 1;
        drive(64'h100, 5'd5, 64'd7, 5'd6, 64'd3, 64'h55, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
        tick();
        in_valid = 0;
        chk("single_valid", out_valid, 1);
        chk("single_alu_a", alu_a, 7);
        chk("single_alu_b", alu_b, 3);
        chk("single_alu_sel", alu_sel, 0);
        chk("single_pc", out_pc, 64'h100);
        chk("single_rd", out_rd, 7);
        chk("single_wr", out_reg_write, 1);
        tick();
        chk("single_drained", out_valid, 0);

        // forwarding priority on a held entry, rs1a=3, rs2a=0
        out_ready = 0;
        drive(64'h140, 5'd3, 64'h11, 5'd0, 64'h22, 64'h0, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1);
        tick();
        in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_data = 64'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_data = 64'hBB;
        #1;
        chk("fwd_exmem_prio", alu_a, 64'hAA);
        chk("fwd_sel", alu_sel, 2);
        exmem_reg_write = 0;
        #1;
        chk("fwd_memwb", alu_a, 64'hBB);
        exmem_reg_write = 1; exmem_rd = 5'd0;
        memwb_reg_write = 1; memwb_rd = 5'd0;
        #1;
        chk("fwd_x0_alu_b", alu_b, 64'h22);
        chk("fwd_x0_store", out_store_data, 64'h22);
        chk("fwd_nomatch_a", alu_a, 64'h11);
        exmem_reg_write = 0; memwb_reg_write = 0;
        out_ready = 1;
        tick();
        chk("fwd_drained", out_valid, 0);

        // stall refresh of rs2 from MEM/WB, then backpressure
        out_ready = 0;
        drive(64'h180, 5'd1, 64'h1, 5'd4, 64'h9, 64'h77, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
        tick();
        in_valid = 0;
        memwb_reg_write = 1; memwb_rd = 5'd4; memwb_data = 64'h1234;
        #1;
        chk("refresh_fwd_b", alu_b, 64'h1234);
        tick();
        memwb_reg_write = 0; memwb_data = 64'hDEAD;
        #1;
        chk("refresh_store", out_store_data, 64'h1234);
        chk("refresh_alu_b", alu_b, 64'h1234);
        chk("refresh_valid", out_valid, 1);
        drive(64'h200, 5'd1, 64'h0, 5'd8, 64'h42, 64'h5A5A, 5'd1, 1'b0, 1'b1, 5'd3, 1'b0);
        #1;
        chk("bp_in_ready", in_ready, 0);
        tick();
        chk("bp_pc_hold", out_pc, 64'h180);
        chk("bp_alu_b_hold", alu_b, 64'h1234);
        out_ready = 1;
        #1;
        chk("bp_in_ready_up", in_ready, 1);
        tick();
        in_valid = 0;
        chk("swap_valid", out_valid, 1);
        chk("swap_pc", out_pc, 64'h200);
        chk("swap_alu_b_imm", alu_b, 64'h5A5A);
        chk("swap_store", out_store_data, 64'h42);
        chk("swap_wr", out_reg_write, 0);
        tick();
        chk("swap_drained", out_valid, 0);

        // back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            drive(64'h1000 + 64'(4 * i), 5'd1, 64'(i), 5'd2, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
            #1;
            chk("stream_in_ready", in_ready, 1);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 64'h1000 + 64'(4 * i));
        end
        in_valid = 0;
        tick();
        chk("stream_end", out_valid, 0);

        // flush drops the held entry and same-cycle input
        out_ready = 0;
        drive(64'h300, 5'd1, 64'h0, 5'd2, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
        tick();
        drive(64'h400, 5'd1, 64'h0, 5'd2, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1);
        flush = 1;
        #1;
        chk("flush_in_ready", in_ready, 1);
        tick();
        flush = 0; in_valid = 0;
        #1;
        chk("flush_valid", out_valid, 0);
        chk("flush_pc_dropped", out_pc, 64'h300);

        // async reset mid-stall
        drive(64'h500, 5'd1, 64'h33, 5'd2, 64'h44, 64'h66, 5'd3, 1'b0, 1'b0, 5'd5, 1'b1);
        tick();
        in_valid = 0;
        chk("arst_pre_valid", out_valid, 1);
        chk("arst_pre_alu_a", alu_a, 64'h33);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_store", out_store_data, 0);
        chk("arst_rd", out_rd, 0);
        chk("arst_wr", out_reg_write, 0);
        chk("arst_sel", alu_sel, 0);
        #2;
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
